wb_grf: RTL and testbench

- Write-back end of the MEM/WB pipeline interface.
- Consumes the W-stage register outputs: instruction, PC, ALU result, memory read data, immediate and register-write enable.
- Selects the write-back value and commits it to a 32x32 general register file.
- Serves the two D-stage read ports with same-cycle W->D bypass, and counts retired instructions for the exception/debug logic.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/grf_array.sv | 51 +++++
 rtl/wb_grf.sv | 82 ++++++++
 tb/tb_wb_grf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: write-back select codes, reset PC and the zero register.
package cpu_pkg;

    localparam logic [1:0]  WSEL_ALU = 2'd0;
    localparam logic [1:0]  WSEL_MEM = 2'd1;
    localparam logic [1:0]  WSEL_PC8 = 2'd2;
    localparam logic [1:0]  WSEL_IMM = 2'd3;

    localparam logic [31:0] RESET_PC = 32'h00003000;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_array.sv
// General register file storage with two read ports carrying same-cycle W->D bypass.
module grf_array #(
    parameter int NREG = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    import cpu_pkg::*;

    logic [31:0] r_regs [NREG];
    logic        w_commit;

    assign w_commit = i_we && (i_waddr != REG_ZERO);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Reads are forced to zero while reset is held, ahead of the bypass.
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        if (!i_rst_n || (i_ra1 == REG_ZERO)) begin
            o_rd1 = '0;
        end else if (i_we && (i_waddr == i_ra1)) begin
            o_rd1 = i_wdata;
        end
    end

    always_comb begin
        o_rd2 = r_regs[i_ra2];
        if (!i_rst_n || (i_ra2 == REG_ZERO)) begin
            o_rd2 = '0;
        end else if (i_we && (i_waddr == i_ra2)) begin
            o_rd2 = i_wdata;
        end
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage: selects the write-back value, commits it to grf_array, counts retirements.
// Define WB_GRF_TRACE_EN to print a trace line for every committed register write.
module wb_grf #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wInstr,
    input  logic [31:0] wPc,
    input  logic [31:0] wALURes,
    input  logic [31:0] wMemRead,
    input  logic [31:0] wImm,
    input  logic        wRegWE,
    input  logic [1:0]  wSel,
    input  logic [4:0]  wAddr,
    input  logic [4:0]  dRA1,
    input  logic [4:0]  dRA2,
    output logic [31:0] dRD1,
    output logic [31:0] dRD2,
    output logic [31:0] wData,
    output logic [31:0] retireCnt
);
    import cpu_pkg::*;

    logic [31:0] w_wdata;
    logic        w_bubble;
    logic        w_reset_bubble;
    logic        w_retire;
    logic [31:0] r_retire_cnt;

    always_comb begin
        w_wdata = wALURes;
        unique case (wSel)
            WSEL_ALU: w_wdata = wALURes;
            WSEL_MEM: w_wdata = wMemRead;
            WSEL_PC8: w_wdata = wPc + 32'd8;
            WSEL_IMM: w_wdata = wImm;
            default:  w_wdata = wALURes;
        endcase
    end

    assign wData = w_wdata;

    // A reset bubble is a special kind of bubble; neither one retires.
    assign w_bubble       = (wInstr == 32'd0);
    assign w_reset_bubble = w_bubble && (wPc == RESET_PC);
    assign w_retire       = !(w_bubble || w_reset_bubble);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retireCnt = r_retire_cnt;

    grf_array #(
        .NREG (NREG)
    ) u_grf_array (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (wRegWE),
        .i_waddr (wAddr),
        .i_wdata (w_wdata),
        .i_ra1   (dRA1),
        .i_ra2   (dRA2),
        .o_rd1   (dRD1),
        .o_rd2   (dRD2)
    );

`ifdef WB_GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wRegWE && (wAddr != REG_ZERO)) begin
            $display("@%h: $%d <= %h", wPc, wAddr, w_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reset, write/readback, zero register, bypass, retire count, async reset.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] wInstr;
    logic [31:0] wPc;
    logic [31:0] wALURes;
    logic [31:0] wMemRead;
    logic [31:0] wImm;
    logic        wRegWE;
    logic [1:0]  wSel;
    logic [4:0]  wAddr;
    logic [4:0]  dRA1;
    logic [4:0]  dRA2;
    logic [31:0] dRD1;
    logic [31:0] dRD2;
    logic [31:0] wData;
    logic [31:0] retireCnt;

    int checks = 0;
    int errors = 0;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .wInstr    (wInstr),
        .wPc       (wPc),
        .wALURes   (wALURes),
        .wMemRead  (wMemRead),
        .wImm      (wImm),
        .wRegWE    (wRegWE),
        .wSel      (wSel),
        .wAddr     (wAddr),
        .dRA1      (dRA1),
        .dRA2      (dRA2),
        .dRD1      (dRD1),
        .dRD2      (dRD2),
        .wData     (wData),
        .retireCnt (retireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        wInstr   = 32'd0;
        wPc      = 32'h00003000;
        wALURes  = 32'd0;
        wMemRead = 32'd0;
        wImm     = 32'd0;
        wRegWE   = 1'b0;
        wSel     = 2'd0;
        wAddr    = 5'd0;
        dRA1     = 5'd1;
        dRA2     = 5'd31;

        // reset held: reads zero, wData still follows wSel
        tick();
        tick();
        wSel = 2'd3;
        wImm = 32'h000000A5;
        #1;
        check("rst_rd1", dRD1, 32'h0);
        check("rst_rd2", dRD2, 32'h0);
        check("rst_cnt", retireCnt, 32'h0);
        check("rst_wdata_imm", wData, 32'h000000A5);
        wSel = 2'd0;

        // release reset between edges
        #2;
        reset = 1'b1;
        #1;
        check("rel_rd1", dRD1, 32'h0);
        check("rel_rd2", dRD2, 32'h0);
        check("rel_cnt", retireCnt, 32'h0);

        // write and readback $5
        tick();
        wSel    = 2'd0;
        wALURes = 32'h12345678;
        wAddr   = 5'd5;
        wRegWE  = 1'b1;
        tick();
        wRegWE  = 1'b0;
        dRA1    = 5'd5;
        #1;
        check("wr_rd_5", dRD1, 32'h12345678);

        // zero register write is ignored
        wSel   = 2'd3;
        wImm   = 32'hFFFFFFFF;
        wAddr  = 5'd0;
        wRegWE = 1'b1;
        dRA1   = 5'd0;
        dRA2   = 5'd0;
        #1;
        check("zero_wdata", wData, 32'hFFFFFFFF);
        check("zero_same_rd1", dRD1, 32'h0);
        check("zero_same_rd2", dRD2, 32'h0);
        tick();
        wRegWE = 1'b0;
        #1;
        check("zero_later_rd1", dRD1, 32'h0);

        // same-cycle bypass on both ports, PC+8
        wSel   = 2'd2;
        wPc    = 32'h00003004;
        wAddr  = 5'd31;
        wRegWE = 1'b1;
        dRA1   = 5'd31;
        dRA2   = 5'd31;
        #1;
        check("byp_rd1", dRD1, 32'h0000300C);
        check("byp_rd2", dRD2, 32'h0000300C);
        check("byp_wdata", wData, 32'h0000300C);
        tick();
        wRegWE  = 1'b0;
        wSel    = 2'd0;
        wALURes = 32'h0;
        #1;
        check("arr_rd_31", dRD1, 32'h0000300C);

        // PC+8 wrap and MEM select
        wSel = 2'd2;
        wPc  = 32'hFFFFFFFC;
        #1;
        check("pc8_wrap", wData, 32'h00000004);
        wSel     = 2'd1;
        wMemRead = 32'hCAFEF00D;
        #1;
        check("sel_mem", wData, 32'hCAFEF00D);

        // one port bypasses, the other reads the array
        wSel    = 2'd0;
        wALURes = 32'h11111111;
        wAddr   = 5'd5;
        wRegWE  = 1'b1;
        dRA1    = 5'd5;
        dRA2    = 5'd31;
        #1;
        check("mix_byp_rd1", dRD1, 32'h11111111);
        check("mix_arr_rd2", dRD2, 32'h0000300C);
        tick();
        wRegWE = 1'b0;
        wALURes = 32'h0;
        #1;
        check("mix_after_rd1", dRD1, 32'h11111111);
        check("cnt_before_retire", retireCnt, 32'h0);

        // retire count: 3 instructions then 2 reset bubbles
        wInstr = 32'h3C011234;
        wPc    = 32'h00003010;
        tick();
        check("cnt_1", retireCnt, 32'd1);
        tick();
        tick();
        wInstr = 32'h0;
        wPc    = 32'h00003000;
        tick();
        tick();
        check("cnt_3", retireCnt, 32'd3);

        // write $7 then async reset mid-cycle
        wSel    = 2'd0;
        wALURes = 32'hDEADBEEF;
        wAddr   = 5'd7;
        wRegWE  = 1'b1;
        tick();
        wRegWE = 1'b0;
        dRA1   = 5'd7;
        dRA2   = 5'd31;
        #1;
        check("pre_rst_rd7", dRD1, 32'hDEADBEEF);
        #2;
        reset = 1'b0;
        #1;
        check("arst_rd7", dRD1, 32'h0);
        check("arst_cnt", retireCnt, 32'h0);

        // write pending across an edge with reset low is lost
        wALURes = 32'h00000055;
        wAddr   = 5'd8;
        wRegWE  = 1'b1;
        wInstr  = 32'h3C011234;
        tick();
        check("arst_hold_cnt", retireCnt, 32'h0);
        wRegWE = 1'b0;
        wInstr = 32'h0;
        #2;
        reset = 1'b1;
        dRA1  = 5'd8;
        #1;
        check("lost_wr_8", dRD1, 32'h0);
        check("cleared_31", dRD2, 32'h0);
        dRA1 = 5'd7;
        #1;
        check("cleared_7", dRD1, 32'h0);
        tick();
        check("post_rst_cnt", retireCnt, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
